// File: rtl/display_mux_ctrl.sv
// Two-digit seven-segment multiplexer: alternates digits with a blanked dead-time
// before each digit is lit, and latches s0+s1 once per frame.
module display_mux_ctrl #(
    parameter int REFRESH_DIV  = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] hex_sel,
    output logic [1:0] an,
    output logic       slot,
    output logic       frame_tick,
    output logic [4:0] sum
);

    localparam int CNT_W       = $clog2(REFRESH_DIV);
    localparam int SHOW_CYCLES = REFRESH_DIV - BLANK_CYCLES;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

    typedef enum logic [1:0] {BLANK0, SHOW0, BLANK1, SHOW1} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       hex_nx;
    logic [1:0]       an_nx;
    logic             slot_nx, tick_nx, sum_ld;

    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state      <= BLANK0;
            cnt        <= '0;
            hex_sel    <= '0;
            an         <= 2'b11;
            slot       <= 1'b0;
            frame_tick <= 1'b0;
            sum        <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            hex_sel    <= hex_nx;
            an         <= an_nx;
            slot       <= slot_nx;
            frame_tick <= tick_nx;
            if (sum_ld)
                sum <= {1'b0, s0} + {1'b0, s1};
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        case (state)
            BLANK0: if (cnt == BLANK_LAST) begin state_nx = SHOW0;  cnt_nx = '0; end
            SHOW0:  if (cnt == SHOW_LAST)  begin state_nx = BLANK1; cnt_nx = '0; end
            BLANK1: if (cnt == BLANK_LAST) begin state_nx = SHOW1;  cnt_nx = '0; end
            SHOW1:  if (cnt == SHOW_LAST)  begin state_nx = BLANK0; cnt_nx = '0; end
            default: begin state_nx = BLANK0; cnt_nx = '0; end
        endcase
        // Disable parks the sequencer at the start of a frame, restarting BLANK0.
        if (!en) begin
            state_nx = BLANK0;
            cnt_nx   = '0;
        end

        // Outputs are decoded from the next state so they register alongside it.
        an_nx = 2'b11;
        case (state_nx)
            SHOW0:   an_nx = 2'b10;
            SHOW1:   an_nx = 2'b01;
            default: an_nx = 2'b11;
        endcase
        slot_nx = (state_nx == BLANK1) || (state_nx == SHOW1);

        // Digit data only moves while both anodes are dark; held through SHOW.
        hex_nx = hex_sel;
        if (state_nx == BLANK0)
            hex_nx = s0;
        else if (state_nx == BLANK1)
            hex_nx = s1;

        sum_ld  = (state_nx == BLANK0) && ((state != BLANK0) || !en);
        tick_nx = en && (state == SHOW1) && (state_nx == BLANK0);
    end

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Bench for display_mux_ctrl: frame-position model checked every cycle, plus
// directed literal expectations and random-run invariants.
module tb_display_mux_ctrl;

    localparam int R     = 8;
    localparam int B     = 2;
    localparam int FRAME = 2 * R;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b1;
    logic [3:0] s0    = 4'h0;
    logic [3:0] s1    = 4'h0;
    logic [3:0] hex_sel;
    logic [1:0] an;
    logic       slot, frame_tick;
    logic [4:0] sum;

    int errors = 0;
    int checks = 0;

    display_mux_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .int_osc(clk), .reset(reset), .en(en), .s0(s0), .s1(s1),
        .hex_sel(hex_sel), .an(an), .slot(slot), .frame_tick(frame_tick), .sum(sum)
    );

    always #5 clk = ~clk;

    // Model: position within a 16-cycle frame decides everything.
    int         pos    = 0;
    logic [3:0] m_hex  = 4'h0;
    logic [4:0] m_sum  = 5'h0;
    logic       m_tick = 1'b0;

    function automatic int next_pos(input int p);
        return (p + 1) % FRAME;
    endfunction

    function automatic logic [1:0] exp_an(input int p);
        if (p < B || (p >= R && p < R + B)) return 2'b11;
        if (p < R) return 2'b10;
        return 2'b01;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pos    <= 0;
            m_hex  <= 4'h0;
            m_sum  <= 5'h0;
            m_tick <= 1'b0;
        end else if (!en) begin
            pos    <= 0;
            m_hex  <= s0;
            m_sum  <= 5'(s0) + 5'(s1);
            m_tick <= 1'b0;
        end else begin
            pos    <= next_pos(pos);
            m_tick <= (next_pos(pos) == 0);
            if (next_pos(pos) == 0)
                m_sum <= 5'(s0) + 5'(s1);
            if (next_pos(pos) < B)
                m_hex <= s0;
            else if (next_pos(pos) >= R && next_pos(pos) < R + B)
                m_hex <= s1;
        end
    end

    logic [3:0] prev_hex = 4'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance n cycles, comparing against the model and invariants at each negedge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("model_an",   32'(an),         32'(exp_an(pos)));
            chk("model_slot", 32'(slot),       32'(pos >= R));
            chk("model_hex",  32'(hex_sel),    32'(m_hex));
            chk("model_sum",  32'(sum),        32'(m_sum));
            chk("model_tick", 32'(frame_tick), 32'(m_tick));
            chk("an_not_00",  32'(an != 2'b00), 32'd1);
            if (hex_sel !== prev_hex)
                chk("hex_change_dark", 32'(an), 32'(2'b11));
            if (an == 2'b10) chk("slot_lit0", 32'(slot), 32'd0);
            if (an == 2'b01) chk("slot_lit1", 32'(slot), 32'd1);
            prev_hex = hex_sel;
        end
    endtask

    initial begin
        s0 = 4'h3; s1 = 4'hA; en = 1'b1;
        #1 reset = 1'b1;
        tick(1);
        chk("rst_an", 32'(an), 32'h3);
        chk("rst_hex", 32'(hex_sel), 32'h0);
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        reset = 1'b0;

        // Basic sequence
        tick(1);  chk("p1_an", 32'(an), 32'h3); chk("p1_hex", 32'(hex_sel), 32'h3);
        tick(1);  chk("p2_an", 32'(an), 32'h2); chk("p2_hex", 32'(hex_sel), 32'h3);
        tick(6);  chk("p8_an", 32'(an), 32'h3); chk("p8_hex", 32'(hex_sel), 32'hA);
                  chk("p8_slot", 32'(slot), 32'h1);
        tick(2);  chk("p10_an", 32'(an), 32'h1);
        tick(5);  chk("p15_tick", 32'(frame_tick), 32'h0); chk("p15_sum", 32'(sum), 32'h0);
        tick(1);  chk("f2_tick", 32'(frame_tick), 32'h1); chk("f2_sum", 32'(sum), 32'h0D);
                  chk("f2_hex", 32'(hex_sel), 32'h3);
        tick(1);  chk("f2p1_tick", 32'(frame_tick), 32'h0);

        // Mid-slot data change is held off until the next blank
        s0 = 4'hF; s1 = 4'hF;
        tick(7);  chk("ff_p8_hex", 32'(hex_sel), 32'hF);
        tick(8);  chk("ff_sum", 32'(sum), 32'h1E); chk("ff_hex", 32'(hex_sel), 32'hF);
        tick(3);  s0 = 4'h0;
        tick(1);  chk("held_hex", 32'(hex_sel), 32'hF); chk("held_an", 32'(an), 32'h2);
        tick(12); chk("new_hex", 32'(hex_sel), 32'h0); chk("new_sum", 32'(sum), 32'h0F);
                  chk("new_tick", 32'(frame_tick), 32'h1);

        // Disable mid-SHOW1
        tick(13); chk("pre_dis_an", 32'(an), 32'h1);
        en = 1'b0;
        tick(1);  chk("dis_an", 32'(an), 32'h3); chk("dis_slot", 32'(slot), 32'h0);
                  chk("dis_tick", 32'(frame_tick), 32'h0); chk("dis_sum", 32'(sum), 32'h0F);
        tick(4);  chk("park_an", 32'(an), 32'h3);
        en = 1'b1;
        tick(1);  chk("ren_an1", 32'(an), 32'h3);
        tick(1);  chk("ren_an2", 32'(an), 32'h2);

        // Asynchronous reset mid-SHOW0
        tick(2);  s0 = 4'h5;
        #2 reset = 1'b1;
        #1;
        chk("arst_an", 32'(an), 32'h3);
        chk("arst_hex", 32'(hex_sel), 32'h0);
        chk("arst_sum", 32'(sum), 32'h0);
        chk("arst_slot", 32'(slot), 32'h0);
        tick(1);  reset = 1'b0;
        tick(1);  chk("rel_an", 32'(an), 32'h3); chk("rel_hex", 32'(hex_sel), 32'h5);
        tick(1);  chk("rel_an2", 32'(an), 32'h2);

        // Random run
        for (int i = 0; i < 10000; i++) begin
            s0 = 4'($urandom_range(0, 15));
            s1 = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 19) != 0);
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
